// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types, encodings and source-match helper for the hazard controller
package hazard_ctrl_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  // x0 is hardwired zero, so a producer targeting it never satisfies a consumer
  function automatic logic src_match(logic [REG_W-1:0] src, logic [REG_W-1:0] dst, logic we);
    return we && dst != '0 && src == dst;
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: operand forwarding selects, WB->ID bypass and load-use detection
//   inputs : ID/EX source indices, ID use flags, EX/MEM/WB destinations and write-enables, EX is-load
//   outputs: fwd_a/fwd_b (EX operand select), fwd_c/fwd_d (ID/EX capture of WB data), load_use
module hazard_match import hazard_ctrl_pkg::*; (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_we,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_we,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_c,
  output logic             fwd_d,
  output logic             load_use
);
  always_comb begin
    fwd_a = src_match(ex_rs1, mem_rd, mem_we) ? FWD_MEM : src_match(ex_rs1, wb_rd, wb_we) ? FWD_WB : FWD_RF;
    fwd_b = src_match(ex_rs2, mem_rd, mem_we) ? FWD_MEM : src_match(ex_rs2, wb_rd, wb_we) ? FWD_WB : FWD_RF;
    fwd_c = src_match(id_rs1, wb_rd, wb_we);
    fwd_d = src_match(id_rs2, wb_rd, wb_we);
    load_use = ex_load && ((id_use1 && src_match(id_rs1, ex_rd, ex_we)) || (id_use2 && src_match(id_rs2, ex_rd, ex_we)));
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with hlt drain-and-freeze FSM
//   inputs : ID/EX/MEM/WB register indices and enables, id_hlt, ex_redirect
//   outputs: pc_hold, ifid_hold, ifid_flush, bubble, forwardA..D, halted, stall_count
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_read_reg1,
  input  logic [REG_W-1:0] id_read_reg2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_hlt,
  input  logic [REG_W-1:0] ex_read_reg1,
  input  logic [REG_W-1:0] ex_read_reg2,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_reg_write,
  input  logic             ex_mem_reg,
  input  logic             ex_redirect,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_write_reg,
  input  logic             wb_reg_write,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             bubble,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             forwardC,
  output logic             forwardD,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  state_t state;
  logic [DW-1:0] cnt;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_c, fwd_d, load_use, run;
  hazard_match u_match (
    .id_rs1(id_read_reg1), .id_rs2(id_read_reg2), .id_use1(id_uses_rs1), .id_use2(id_uses_rs2),
    .ex_rs1(ex_read_reg1), .ex_rs2(ex_read_reg2), .ex_rd(ex_write_reg), .ex_we(ex_reg_write),
    .ex_load(ex_mem_reg), .mem_rd(mem_write_reg), .mem_we(mem_reg_write),
    .wb_rd(wb_write_reg), .wb_we(wb_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .fwd_d(fwd_d), .load_use(load_use)
  );
  // reset is applied combinationally too so the pipeline sees a flush+bubble while rst_n is low
  always_comb begin
    run = state == RUN;
    pc_hold = rst_n && (run ? load_use && !ex_redirect : 1'b1);
    ifid_hold = pc_hold;
    ifid_flush = !rst_n || (run && ex_redirect);
    bubble = !rst_n || !run || ex_redirect || load_use;
    forwardA = rst_n ? fwd_a : FWD_RF;
    forwardB = rst_n ? fwd_b : FWD_RF;
    forwardC = rst_n && fwd_c;
    forwardD = rst_n && fwd_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
      halted <= 1'b0;
      stall_count <= '0;
    end else begin
      if (bubble && stall_count != '1) stall_count <= stall_count + 1'b1;
      case (state)
        RUN: if (id_hlt && !ex_redirect) begin
          state <= DRAIN;
          cnt <= DW'(DRAIN_CYCLES);
        end
        DRAIN: begin
          cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
          if (cnt <= DW'(1)) begin
            state <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end
endmodule
